cpu_trace_monitor: RTL and testbench
====================================

Name: cpu_trace_monitor

Overview:
- Synthesizable execution-trace and run-control monitor attached to the CPU retire/writeback interface.
- Records one entry per retired instruction into a circular trace buffer and counts cycles and retirements.
- Detects halt and enforces a cycle watchdog.
- Trace is drained through a valid/ready read port, so the same trace is available in simulation and on hardware.
- Generalises the fixed 8-bit / 150-cycle bench monitoring to parametrised widths, depth and timeout.

Parameters:
DATA_W, 8, register/writeback data width
PC_W, 8, program counter width
INSTR_W, 16, instruction word width
DEPTH, 16, trace buffer entries; power of 2, minimum 2
TIMEOUT_CYCLES, 150, RUN-state cycles before watchdog fires; minimum 1
CNT_W, 16, width of cycle and retire counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
clear  in  1  synchronous restart: FSM to IDLE, counters and buffer emptied, flags cleared
start  in  1  level; IDLE->RUN when high
retire_valid  in  1  one instruction retires this cycle
retire_pc  in  PC_W  PC of retiring instruction
retire_instr  in  INSTR_W  retiring instruction word
wb_en  in  1  retiring instruction writes a register
wb_addr  in  3  destination register index
wb_data  in  DATA_W  written value
halt  in  1  CPU halt indication
rd_ready  in  1  consumer accepts rd_data
rd_valid  out  1  buffer non-empty
rd_data  out  TRACE_W  oldest entry; TRACE_W = 4+DATA_W+INSTR_W+PC_W
state  out  2  00 IDLE, 01 RUN, 10 HALTED, 11 TIMEOUT
cycle_count  out  CNT_W  cycles spent in RUN
retire_count  out  CNT_W  entries offered for capture
overflow  out  1  sticky: an entry was lost or overwritten
done  out  1  state is HALTED or TIMEOUT

Behaviour:
- Reset (async, rst=1): state=IDLE; cycle_count=0; retire_count=0; overflow=0; done=0; rd_valid=0; rd_data=0; pointers and occupancy=0.
- clear has priority over all other inputs except rst. Same effect as reset, applied on the next edge.
- Entry format, MSB to LSB: {wb_en, wb_addr, wb_data, retire_instr, retire_pc}. When wb_en=0, wb_addr and wb_data are stored as 0.
- FSM transitions:
  - IDLE: no capture, counters frozen. start=1 -> RUN.
  - RUN: cycle_count increments every cycle, saturating at all-ones. A retire_valid=1 cycle pushes an entry and increments retire_count (saturating).
  - RUN, halt=1: the same-cycle retire is captured, then -> HALTED.
  - RUN, cycle_count==TIMEOUT_CYCLES-1 and halt=0: -> TIMEOUT. Any retire in that final cycle is still captured.
  - RUN, halt and timeout condition in the same cycle: HALTED wins.
  - HALTED/TIMEOUT: terminal. No capture, counters frozen. Exit only via clear or rst.
- done is registered: goes high on the edge that enters HALTED/TIMEOUT.
- Read port (works in every state):
  - rd_valid = occupancy != 0.
  - rd_data is the head entry combinationally from the registered buffer.
  - Pop on rd_valid & rd_ready.
  - rd_ready while empty is ignored.
- Push latency: an entry pushed at edge N is visible on rd_data at N if the buffer was empty; rd_valid rises after edge N.
- Pointers wrap modulo DEPTH. occupancy ranges 0..DEPTH.
- Simultaneous push and pop:
  - Non-empty buffer: occupancy unchanged, both pointers advance.
  - Empty buffer: push only; nothing to pop.
  - Full buffer with a pop: no overflow.
- Full with push and no pop: governed by Optional Feature. overflow is set either way.

Optional Feature:
Macro TRACE_STOP_ON_FULL_EN.
- Defined: a push into a full buffer is dropped. Buffer contents unchanged, retire_count still increments, overflow set.
- Undefined (default): flight-recorder mode. The oldest entry is overwritten, the read pointer advances with the write pointer, occupancy stays DEPTH and overflow is set. The buffer always holds the newest DEPTH retirements.

Test Plan:
- Reset mid-RUN after 5 retires -> all outputs 0 and state=00 immediately, with no clock edge needed.
- start=1, retire 3 entries (pc 0,1,2; wb R4=50 on pc1), halt with pc2 -> state=10, done=1, retire_count=3, and drain yields 3 entries in order, entry1 = {1,4,50,instr,1}.
- start=1, no halt, TIMEOUT_CYCLES=150 -> state=11 after exactly 150 RUN cycles, cycle_count=150.
- halt asserted on cycle 149 of RUN -> state=10, not 11.
- DEPTH=16, 20 retires with no reads, default build -> overflow=1, 16 entries drained with pc 4..19. With TRACE_STOP_ON_FULL_EN -> pc 0..15, retire_count=20.
- Full buffer, retire_valid and rd_ready asserted together for 4 cycles -> overflow stays 0, occupancy stays 16, order preserved.

Source files
------------

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor
// Execution-trace and run-control monitor attached to a CPU retire/writeback
// interface. One entry per retired instruction is recorded into a circular
// trace buffer. The monitor also counts RUN cycles and retirements, detects
// halt, and enforces a cycle watchdog. The trace is drained through a
// valid/ready read port.
//
// Entry format, MSB to LSB: {wb_en, wb_addr, wb_data, retire_instr, retire_pc}.
// wb_addr and wb_data are stored as zero when wb_en is low.
//
// Configuration macro TRACE_STOP_ON_FULL_EN:
//   defined   - a push into a full buffer is dropped
//   undefined - flight recorder: the oldest entry is overwritten
// In both modes the sticky overflow flag is set.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   clear           synchronous restart (IDLE, counters/buffer/flags cleared)
//   start           level, IDLE -> RUN
//   retire_*, wb_*  retire/writeback observation bus
//   halt            CPU halt indication
//   rd_ready        consumer accepts rd_data
//   rd_valid        buffer non-empty
//   rd_data         oldest entry (zero when empty)
//   state           00 IDLE, 01 RUN, 10 HALTED, 11 TIMEOUT
//   cycle_count     cycles spent in RUN (saturating)
//   retire_count    entries offered for capture (saturating)
//   overflow        sticky, an entry was lost or overwritten
//   done            registered, state is HALTED or TIMEOUT
module cpu_trace_monitor #(
  parameter int DATA_W         = 8,
  parameter int PC_W           = 8,
  parameter int INSTR_W        = 16,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 150,
  parameter int CNT_W          = 16,
  localparam int TRACE_W       = 4 + DATA_W + INSTR_W + PC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               start,
  input  logic               retire_valid,
  input  logic [PC_W-1:0]    retire_pc,
  input  logic [INSTR_W-1:0] retire_instr,
  input  logic               wb_en,
  input  logic [2:0]         wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               halt,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [TRACE_W-1:0] rd_data,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   retire_count,
  output logic               overflow,
  output logic               done
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [OW-1:0]    OCC_FULL     = OW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_HALTED  = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   retire_q, retire_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]      occ_q, occ_d;
  logic               push_s, pop_s, full_s, wr_en_s;
  logic [TRACE_W-1:0] entry_s;
  logic [TRACE_W-1:0] mem_q [DEPTH];

  // Trace entry assembly; register fields are masked when nothing is written.
  assign entry_s = {wb_en,
                    wb_en ? wb_addr : 3'b000,
                    wb_en ? wb_data : {DATA_W{1'b0}},
                    retire_instr,
                    retire_pc};

  // Run-control FSM next state, counters and capture request.
  always_comb begin
    state_d  = state_q;
    cycle_d  = cycle_q;
    retire_d = retire_q;
    push_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (cycle_q != CNT_MAX) cycle_d = cycle_q + CNT_W'(1);
        else                    cycle_d = cycle_q;
        if (retire_valid) begin
          push_s = 1'b1;
          if (retire_q != CNT_MAX) retire_d = retire_q + CNT_W'(1);
          else                     retire_d = retire_q;
        end else begin
          push_s = 1'b0;
        end
        // Halt has precedence over a coincident watchdog expiry.
        if (halt)                         state_d = ST_HALTED;
        else if (cycle_q == TIMEOUT_LAST) state_d = ST_TIMEOUT;
        else                              state_d = ST_RUN;
      end
      ST_HALTED, ST_TIMEOUT: state_d = state_q;
      default:               state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_HALTED) || (state_d == ST_TIMEOUT);
  end

  assign full_s = (occ_q == OCC_FULL);
  assign pop_s  = (occ_q != {OW{1'b0}}) && rd_ready;

  // Trace buffer pointer/occupancy update and overflow tracking.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    overflow_d = overflow_q;
    wr_en_s    = 1'b0;
    if (push_s && pop_s) begin
      // Simultaneous push and pop never loses data, even when full.
      wr_en_s  = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else if (push_s && full_s) begin
      overflow_d = 1'b1;
`ifdef TRACE_STOP_ON_FULL_EN
      wr_en_s = 1'b0;
`else
      // Full buffer: wr_ptr equals rd_ptr, so the oldest slot is replaced.
      wr_en_s  = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      rd_ptr_d = rd_ptr_q + AW'(1);
`endif
    end else if (push_s) begin
      wr_en_s  = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      occ_d    = occ_q + OW'(1);
    end else if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      occ_d    = occ_q - OW'(1);
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Control and status registers with async reset and synchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cycle_q    <= {CNT_W{1'b0}};
      retire_q   <= {CNT_W{1'b0}};
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      occ_q      <= {OW{1'b0}};
    end else if (clear) begin
      state_q    <= ST_IDLE;
      cycle_q    <= {CNT_W{1'b0}};
      retire_q   <= {CNT_W{1'b0}};
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      occ_q      <= {OW{1'b0}};
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      retire_q   <= retire_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // Trace storage; contents need no reset because rd_data is masked when empty.
  always_ff @(posedge clk) begin
    if (wr_en_s && !clear) mem_q[wr_ptr_q] <= entry_s;
  end

  assign rd_valid     = (occ_q != {OW{1'b0}});
  assign rd_data      = rd_valid ? mem_q[rd_ptr_q] : {TRACE_W{1'b0}};
  assign state        = state_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
  assign overflow     = overflow_q;
  assign done         = done_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed self-checking bench for cpu_trace_monitor (default parameters).
module tb_cpu_trace_monitor;

  localparam int TRACE_W = 36;

  logic               clk;
  logic               rst;
  logic               clear;
  logic               start;
  logic               retire_valid;
  logic [7:0]         retire_pc;
  logic [15:0]        retire_instr;
  logic               wb_en;
  logic [2:0]         wb_addr;
  logic [7:0]         wb_data;
  logic               halt;
  logic               rd_ready;
  logic               rd_valid;
  logic [TRACE_W-1:0] rd_data;
  logic [1:0]         state;
  logic [15:0]        cycle_count;
  logic [15:0]        retire_count;
  logic               overflow;
  logic               done;

  int checks   = 0;
  int failures = 0;

  cpu_trace_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .start        (start),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .retire_instr (retire_instr),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .halt         (halt),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .state        (state),
    .cycle_count  (cycle_count),
    .retire_count (retire_count),
    .overflow     (overflow),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int p;
    logic [35:0] exp_e;

    rst = 1'b1; clear = 1'b0; start = 1'b0; retire_valid = 1'b0;
    retire_pc = 8'h00; retire_instr = 16'h0000; wb_en = 1'b0;
    wb_addr = 3'd0; wb_data = 8'h00; halt = 1'b0; rd_ready = 1'b0;

    // Reset state
    #12;
    check("rst_state", 64'(state), 64'd0);
    check("rst_cycle", 64'(cycle_count), 64'd0);
    check("rst_retire", 64'(retire_count), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Async reset mid-RUN after 5 retires
    start = 1'b1;
    step();
    check("run_enter", 64'(state), 64'd1);
    retire_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      retire_pc = 8'(i);
      retire_instr = 16'h3000 + 16'(i);
      step();
    end
    retire_valid = 1'b0;
    check("mid_retire", 64'(retire_count), 64'd5);
    check("mid_rd_valid", 64'(rd_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_state", 64'(state), 64'd0);
    check("async_cycle", 64'(cycle_count), 64'd0);
    check("async_retire", 64'(retire_count), 64'd0);
    check("async_rd_valid", 64'(rd_valid), 64'd0);
    check("async_rd_data", 64'(rd_data), 64'd0);
    check("async_overflow", 64'(overflow), 64'd0);
    check("async_done", 64'(done), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    step();
    check("post_rst_idle", 64'(state), 64'd0);

    // Three retires, halt on the third
    start = 1'b1;
    step();
    retire_valid = 1'b1;
    retire_pc = 8'd0; retire_instr = 16'h1000; wb_en = 1'b0; wb_addr = 3'd7; wb_data = 8'hAA;
    step();
    retire_pc = 8'd1; retire_instr = 16'h1001; wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'd50;
    step();
    retire_pc = 8'd2; retire_instr = 16'h1002; wb_en = 1'b0; wb_addr = 3'd7; wb_data = 8'hAA;
    halt = 1'b1;
    step();
    retire_valid = 1'b0; halt = 1'b0; wb_en = 1'b0;
    check("halt_state", 64'(state), 64'd2);
    check("halt_done", 64'(done), 64'd1);
    check("halt_retire", 64'(retire_count), 64'd3);
    check("halt_cycle", 64'(cycle_count), 64'd3);
    check("halt_e0_valid", 64'(rd_valid), 64'd1);
    check("halt_e0", 64'(rd_data), 64'h000100000);
    rd_ready = 1'b1;
    step();
    check("halt_e1", 64'(rd_data), 64'hC32100101);
    step();
    check("halt_e2", 64'(rd_data), 64'h000100202);
    step();
    check("drained_valid", 64'(rd_valid), 64'd0);
    check("drained_data", 64'(rd_data), 64'd0);
    step();
    check("empty_ready_valid", 64'(rd_valid), 64'd0);
    rd_ready = 1'b0;
    retire_valid = 1'b1;
    step();
    retire_valid = 1'b0;
    check("halted_no_capture", 64'(retire_count), 64'd3);
    check("halted_no_push", 64'(rd_valid), 64'd0);
    check("halted_terminal", 64'(state), 64'd2);

    // Watchdog timeout after exactly 150 RUN cycles
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_state", 64'(state), 64'd0);
    check("clear_cycle", 64'(cycle_count), 64'd0);
    check("clear_retire", 64'(retire_count), 64'd0);
    check("clear_done", 64'(done), 64'd0);
    step();
    check("to_run", 64'(state), 64'd1);
    repeat (149) step();
    check("to_149_state", 64'(state), 64'd1);
    check("to_149_cycle", 64'(cycle_count), 64'd149);
    step();
    check("to_state", 64'(state), 64'd3);
    check("to_cycle", 64'(cycle_count), 64'd150);
    check("to_done", 64'(done), 64'd1);
    step();
    check("to_frozen", 64'(cycle_count), 64'd150);

    // Halt coincident with the watchdog's final cycle
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    repeat (149) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_wins_state", 64'(state), 64'd2);
    check("halt_wins_cycle", 64'(cycle_count), 64'd150);
    check("halt_wins_done", 64'(done), 64'd1);

    // 20 retires into a 16-entry buffer with no reads
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    retire_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      retire_pc = 8'(i);
      retire_instr = 16'h2000 + 16'(i);
      step();
    end
    retire_valid = 1'b0;
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_retire", 64'(retire_count), 64'd20);
`ifdef TRACE_STOP_ON_FULL_EN
    base = 0;
`else
    base = 4;
`endif
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      p = base + i;
      exp_e = {12'h000, 16'h2000 + 16'(p), 8'(p)};
      check("ovf_drain_valid", 64'(rd_valid), 64'd1);
      check("ovf_drain_data", 64'(rd_data), 64'(exp_e));
      step();
    end
    check("ovf_drained", 64'(rd_valid), 64'd0);
    rd_ready = 1'b0;

    // Full buffer with push and pop together for 4 cycles
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_ovf", 64'(overflow), 64'd0);
    step();
    retire_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      retire_pc = 8'(i);
      retire_instr = 16'h5000 + 16'(i);
      step();
    end
    check("full_no_ovf", 64'(overflow), 64'd0);
    rd_ready = 1'b1;
    for (int i = 16; i < 20; i++) begin
      retire_pc = 8'(i);
      retire_instr = 16'h5000 + 16'(i);
      step();
    end
    retire_valid = 1'b0;
    check("pp_no_ovf", 64'(overflow), 64'd0);
    check("pp_retire", 64'(retire_count), 64'd20);
    for (int i = 0; i < 16; i++) begin
      p = 4 + i;
      exp_e = {12'h000, 16'h5000 + 16'(p), 8'(p)};
      check("pp_drain_valid", 64'(rd_valid), 64'd1);
      check("pp_drain_data", 64'(rd_data), 64'(exp_e));
      step();
    end
    check("pp_drained", 64'(rd_valid), 64'd0);
    check("pp_end_ovf", 64'(overflow), 64'd0);
    rd_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
